aes128_key_expander: RTL and testbench

Iterative AES-128 key schedule. It accepts a 128-bit cipher key, generates one round key per clock, and holds all eleven round keys (round 0 to round 10) in a register bank. The flat round-key bus feeds the decryption datapath directly: it needs round 10 first and round 0 last, and every key is stable before `keys_valid` rises. It replaces per-instance combinational key expansion, giving a shared, registered key source.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes128_key_expander.sv | 87 ++++++++
 tb/tb_aes128_key_expander.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word type, key-schedule FSM encoding
// and the round-constant table used by the key expander.
package aes_pkg;

  localparam logic [3:0] AES_NR    = 4'd10;
  localparam int         AES_NKEYS = 11;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  // Rcon[1..10]; index 0 and 11..15 never reach the datapath while it is used.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    // NOTE: a default assignment before the case keeps combinational code latch-free.
    rc = 8'h00;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, 8-bit combinational lookup. Shared with the encryption
// path; the inverse S-box lives in its own module.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SBOX[data];

endmodule

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slot
// register bank exposed as a flat, registered bus for the decryption datapath.
module aes128_key_expander
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [0:127]  cipher_key,
  output logic          busy,
  output logic          keys_valid,
  output logic [0:1407] round_keys
);

  state_t       state;
  logic [3:0]   cnt;
  logic [0:127] slot [0:AES_NKEYS-1];

  logic [3:0]   prev_idx;
  logic [0:127] prev_key;
  logic [0:127] next_key;
  word_t        w0, w1, w2, w3;
  word_t        rot_w3, sub_w3;
  word_t        n0, n1, n2, n3;

  // Single next-key datapath, fed from the slot written on the previous cycle.
  assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign prev_key = slot[prev_idx];
  assign w0       = prev_key[0:31];
  assign w1       = prev_key[32:63];
  assign w2       = prev_key[64:95];
  assign w3       = prev_key[96:127];
  assign rot_w3   = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data  (rot_w3[8*b +: 8]),
      .subst (sub_w3[8*b +: 8])
    );
  end

  assign n0       = w0 ^ sub_w3 ^ {rcon(cnt), 24'h000000};
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  for (genvar i = 0; i < AES_NKEYS; i++) begin : g_bus
    assign round_keys[128*i +: 128] = slot[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      // NOTE: the key bank is reset too, so no partial schedule survives a reset.
      for (int i = 0; i < AES_NKEYS; i++) slot[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every read sees pre-edge values.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            slot[0]    <= cipher_key;
            cnt        <= 4'd1;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          slot[cnt] <= next_key;
          if (cnt == AES_NR) begin
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench for aes128_key_expander against a FIPS-197 key-schedule
// model whose S-box and Rcon are derived from GF(2^8) arithmetic.
module tb_aes128_key_expander;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [0:127]  cipher_key;
  logic          busy;
  logic          keys_valid;
  logic [0:1407] round_keys;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   sbox_ref [256];
  logic [7:0]   rcon_ref [11];
  logic [127:0] exp_rk   [11];

  always #5 clk = ~clk;

  aes128_key_expander dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .round_keys (round_keys)
  );

  task automatic chk(input string tag, input logic [1407:0] got, input logic [1407:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rk(input int i);
    return round_keys[128*i +: 128];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] rc;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    rcon_ref[0] = 8'h00;
    for (int r = 1; r <= 10; r++) begin
      rcon_ref[r] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  // FIPS-197 KeyExpansion over 44 words, regrouped into 11 round keys.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t ^= {rcon_ref[i/4], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a falling edge: pulses start, follows the 11-cycle timeline and
  // checks every round key. With inject set, start is re-asserted with junk
  // keys so that it is sampled at E3..E9.
  task automatic run_expand(input logic [127:0] key, input bit inject, input string tag);
    build_model(key);
    start      = 1'b1;
    cipher_key = key;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("%s_busy_c%0d", tag, c), busy, (c <= 10));
      chk($sformatf("%s_valid_c%0d", tag, c), keys_valid, (c == 11));
      start      = (inject && c >= 3 && c <= 9);
      cipher_key = rand128();
    end
    start = 1'b0;
    for (int r = 0; r < 11; r++)
      chk($sformatf("%s_rk%0d", tag, r), rk(r), exp_rk[r]);
  endtask

  initial begin
    build_tables();
    rst        = 1'b1;
    start      = 1'b0;
    cipher_key = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", keys_valid, 1'b0);
    chk("reset_keys", round_keys, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", keys_valid, 1'b0);

    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, "fips_a1");
    chk("fips_a1_round1", rk(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_a1_round10", rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Back-to-back restart from DONE on the first keys_valid cycle.
    run_expand(128'h000102030405060708090a0b0c0d0e0f, 1'b0, "seq_key");
    chk("seq_key_round0", rk(0), 128'h000102030405060708090a0b0c0d0e0f);
    chk("seq_key_round10", rk(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    run_expand('0, 1'b0, "zero_key");
    chk("zero_key_round10", rk(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    run_expand(rand128(), 1'b1, "ignored_start");
    repeat (3) @(negedge clk);
    chk("done_hold_valid", keys_valid, 1'b1);
    chk("done_hold_busy", busy, 1'b0);
    chk("done_hold_rk10", rk(10), exp_rk[10]);

    // Asynchronous reset just after E5 of an expansion.
    start      = 1'b1;
    cipher_key = rand128();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_valid", keys_valid, 1'b0);
    chk("midreset_keys", round_keys, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", keys_valid, 1'b0);
    run_expand(rand128(), 1'b0, "after_reset");

    for (int k = 0; k < 3; k++)
      run_expand(rand128(), (k == 1), $sformatf("rand%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
